// File: rtl/data_ram_port_arbiter_if.sv
// Pipeline-side slots, RAM-side ports and status of the data RAM port arbiter.
// Arbiter uses the slave modport; the pipeline/RAM environment uses master.
interface data_ram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  logic              flush;
  logic              req_1, we_1, req_2, we_2;
  logic [ADDR_W-1:0] pc_1, addr_1, pc_2, addr_2;
  logic [3:0]        sel_1, sel_2;
  logic [31:0]       wdata_1, wdata_2;
  logic [31:0]       rdata_1, rdata_2;
  logic              rvalid_1, rvalid_2;
  logic              stall_o;
  logic [CNT_W-1:0]  stall_cnt;
  logic              ram_ce_1, ram_we_1, ram_ce_2, ram_we_2;
  logic [ADDR_W-1:0] ram_pc_1, ram_addr_1, ram_pc_2, ram_addr_2;
  logic [3:0]        ram_sel_1, ram_sel_2;
  logic [31:0]       ram_wdata_1, ram_wdata_2;
  logic [31:0]       ram_rdata_1, ram_rdata_2;

  modport slave (
    input  flush, req_1, we_1, pc_1, addr_1, sel_1, wdata_1,
           req_2, we_2, pc_2, addr_2, sel_2, wdata_2,
           ram_rdata_1, ram_rdata_2,
    output rdata_1, rvalid_1, rdata_2, rvalid_2, stall_o, stall_cnt,
           ram_ce_1, ram_we_1, ram_pc_1, ram_addr_1, ram_sel_1, ram_wdata_1,
           ram_ce_2, ram_we_2, ram_pc_2, ram_addr_2, ram_sel_2, ram_wdata_2
  );

  modport master (
    output flush, req_1, we_1, pc_1, addr_1, sel_1, wdata_1,
           req_2, we_2, pc_2, addr_2, sel_2, wdata_2,
           ram_rdata_1, ram_rdata_2,
    input  rdata_1, rvalid_1, rdata_2, rvalid_2, stall_o, stall_cnt,
           ram_ce_1, ram_we_1, ram_pc_1, ram_addr_1, ram_sel_1, ram_wdata_1,
           ram_ce_2, ram_we_2, ram_pc_2, ram_addr_2, ram_sel_2, ram_wdata_2
  );
endinterface

// File: rtl/data_ram_port_arbiter.sv
// Maps two memory-stage slots onto a dual-port data RAM, merging same-word writes
// and serialising a slot-1 store / slot-2 load to the same word with a 1-cycle stall.
module data_ram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  data_ram_port_arbiter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, SERIAL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d, pend_pc_q, pend_pc_d;
  logic [3:0]        pend_sel_q, pend_sel_d;
  logic              rvalid_1_q, rvalid_1_d, rvalid_2_q, rvalid_2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              same_word, ww_hit, raw_hit, stall;
  logic [31:0]       merged_wdata;
  logic              ram_ce_1, ram_we_1, ram_ce_2, ram_we_2;
  logic [ADDR_W-1:0] ram_pc_1, ram_addr_1, ram_pc_2, ram_addr_2;
  logic [3:0]        ram_sel_1, ram_sel_2;
  logic [31:0]       ram_wdata_1, ram_wdata_2;

  assign same_word = bus.req_1 & bus.req_2 &
                     (bus.addr_1[ADDR_W-1:2] == bus.addr_2[ADDR_W-1:2]);
  assign ww_hit    = same_word & bus.we_1 & bus.we_2;
  assign raw_hit   = same_word & bus.we_1 & ~bus.we_2;

  // Younger slot 2 owns every lane it selects; slot 1 fills the rest.
  always_comb begin
    merged_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      merged_wdata[8*i +: 8] = bus.sel_2[i] ? bus.wdata_2[8*i +: 8] : bus.wdata_1[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_addr_q <= '0;
      pend_pc_q   <= '0;
      pend_sel_q  <= '0;
      rvalid_1_q  <= 1'b0;
      rvalid_2_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      pend_pc_q   <= pend_pc_d;
      pend_sel_q  <= pend_sel_d;
      rvalid_1_q  <= rvalid_1_d;
      rvalid_2_q  <= rvalid_2_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    pend_pc_d   = pend_pc_q;
    pend_sel_d  = pend_sel_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (raw_hit) begin
            state_d     = SERIAL;
            pend_addr_d = bus.addr_2;
            pend_pc_d   = bus.pc_2;
            pend_sel_d  = bus.sel_2;
          end
        end
        SERIAL:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // rst_n gates the ports directly so an async reset idles the RAM without a clock edge.
  always_comb begin
    ram_ce_1    = 1'b0;
    ram_we_1    = 1'b0;
    ram_pc_1    = bus.pc_1;
    ram_addr_1  = bus.addr_1;
    ram_sel_1   = bus.sel_1;
    ram_wdata_1 = bus.wdata_1;
    ram_ce_2    = 1'b0;
    ram_we_2    = 1'b0;
    ram_pc_2    = bus.pc_2;
    ram_addr_2  = bus.addr_2;
    ram_sel_2   = bus.sel_2;
    ram_wdata_2 = bus.wdata_2;
    stall       = 1'b0;
    if (rst_n && !bus.flush) begin
      if (state_q == SERIAL) begin
        ram_ce_2   = 1'b1;
        ram_addr_2 = pend_addr_q;
        ram_pc_2   = pend_pc_q;
        ram_sel_2  = pend_sel_q;
      end else if (ww_hit) begin
        ram_ce_2    = 1'b1;
        ram_we_2    = 1'b1;
        ram_sel_2   = bus.sel_1 | bus.sel_2;
        ram_wdata_2 = merged_wdata;
      end else if (raw_hit) begin
        ram_ce_1 = 1'b1;
        ram_we_1 = 1'b1;
        stall    = 1'b1;
      end else begin
        ram_ce_1 = bus.req_1;
        ram_we_1 = bus.req_1 & bus.we_1;
        ram_ce_2 = bus.req_2;
        ram_we_2 = bus.req_2 & bus.we_2;
      end
    end
  end

  assign rvalid_1_d = ram_ce_1 & ~ram_we_1;
  assign rvalid_2_d = ram_ce_2 & ~ram_we_2;
  assign cnt_d      = (stall && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

  assign bus.ram_ce_1    = ram_ce_1;
  assign bus.ram_we_1    = ram_we_1;
  assign bus.ram_pc_1    = ram_pc_1;
  assign bus.ram_addr_1  = ram_addr_1;
  assign bus.ram_sel_1   = ram_sel_1;
  assign bus.ram_wdata_1 = ram_wdata_1;
  assign bus.ram_ce_2    = ram_ce_2;
  assign bus.ram_we_2    = ram_we_2;
  assign bus.ram_pc_2    = ram_pc_2;
  assign bus.ram_addr_2  = ram_addr_2;
  assign bus.ram_sel_2   = ram_sel_2;
  assign bus.ram_wdata_2 = ram_wdata_2;
  assign bus.stall_o     = stall;
  assign bus.stall_cnt   = cnt_q;
  assign bus.rvalid_1    = rvalid_1_q;
  assign bus.rvalid_2    = rvalid_2_q;
  assign bus.rdata_1     = rvalid_1_q ? bus.ram_rdata_1 : 32'h0;
  assign bus.rdata_2     = rvalid_2_q ? bus.ram_rdata_2 : 32'h0;

endmodule

// File: tb/tb_data_ram_port_arbiter.sv
// Bench: program-order memory model plus per-cycle port expectations; a CNT_W=2 twin checks saturation.
module tb_data_ram_port_arbiter;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } slot_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  data_ram_port_arbiter_if #(.ADDR_W(32), .CNT_W(32)) ifm ();
  data_ram_port_arbiter_if #(.ADDR_W(32), .CNT_W(2))  ifs ();

  data_ram_port_arbiter #(.ADDR_W(32), .CNT_W(32)) dut   (.clk(clk), .rst_n(rst_n), .bus(ifm.slave));
  data_ram_port_arbiter #(.ADDR_W(32), .CNT_W(2))  dut_s (.clk(clk), .rst_n(rst_n), .bus(ifs.slave));

  assign ifs.flush   = ifm.flush;
  assign ifs.req_1   = ifm.req_1;
  assign ifs.we_1    = ifm.we_1;
  assign ifs.pc_1    = ifm.pc_1;
  assign ifs.addr_1  = ifm.addr_1;
  assign ifs.sel_1   = ifm.sel_1;
  assign ifs.wdata_1 = ifm.wdata_1;
  assign ifs.req_2   = ifm.req_2;
  assign ifs.we_2    = ifm.we_2;
  assign ifs.pc_2    = ifm.pc_2;
  assign ifs.addr_2  = ifm.addr_2;
  assign ifs.sel_2   = ifm.sel_2;
  assign ifs.wdata_2 = ifm.wdata_2;

  // Dual-port RAM with registered, read-before-write output, driven by the main DUT
  logic [31:0] ram [0:1023];
  logic [31:0] ram_rd1, ram_rd2;
  assign ifm.ram_rdata_1 = ram_rd1;
  assign ifm.ram_rdata_2 = ram_rd2;
  assign ifs.ram_rdata_1 = ram_rd1;
  assign ifs.ram_rdata_2 = ram_rd2;

  always @(posedge clk) begin
    if (ifm.ram_ce_1 && !ifm.ram_we_1) ram_rd1 <= ram[ifm.ram_addr_1[11:2]];
    if (ifm.ram_ce_2 && !ifm.ram_we_2) ram_rd2 <= ram[ifm.ram_addr_2[11:2]];
    for (int i = 0; i < 4; i++) begin
      if (ifm.ram_ce_1 && ifm.ram_we_1 && ifm.ram_sel_1[i])
        ram[ifm.ram_addr_1[11:2]][8*i +: 8] <= ifm.ram_wdata_1[8*i +: 8];
      if (ifm.ram_ce_2 && ifm.ram_we_2 && ifm.ram_sel_2[i])
        ram[ifm.ram_addr_2[11:2]][8*i +: 8] <= ifm.ram_wdata_2[8*i +: 8];
    end
  end

  // Reference model: architectural memory updated in program order
  logic [31:0] mmem [0:1023];
  bit          m_pend;
  slot_t       m_ps;
  bit          m_rv1, m_rv2;
  logic [31:0] m_rd1, m_rd2;
  int          m_cnt;

  function automatic slot_t mk(input logic r, input logic w, input logic [31:0] pc,
                               input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    slot_t t;
    t.req = r; t.we = w; t.pc = pc; t.addr = a; t.sel = s; t.wdata = d;
    return t;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic mwrite(input slot_t s);
    for (int i = 0; i < 4; i++)
      if (s.sel[i]) mmem[s.addr[11:2]][8*i +: 8] = s.wdata[8*i +: 8];
  endtask

  task automatic chk_port(input string nm, input logic ce, input logic we, input logic [31:0] pc,
                          input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                          input bit e_ce, input slot_t e);
    chk({nm, "_ce"}, ce, e_ce);
    chk({nm, "_we"}, we, e_ce & e.we);
    if (e_ce) begin
      chk({nm, "_addr"}, a, e.addr);
      chk({nm, "_sel"}, s, e.sel);
      chk({nm, "_pc"}, pc, e.pc);
      if (e.we) chk({nm, "_wdata"}, d & lane_mask(e.sel), e.wdata & lane_mask(e.sel));
    end
  endtask

  task automatic drive(input logic fl, input slot_t a, input slot_t b);
    ifm.flush = fl;
    ifm.req_1 = a.req; ifm.we_1 = a.we; ifm.pc_1 = a.pc; ifm.addr_1 = a.addr;
    ifm.sel_1 = a.sel; ifm.wdata_1 = a.wdata;
    ifm.req_2 = b.req; ifm.we_2 = b.we; ifm.pc_2 = b.pc; ifm.addr_2 = b.addr;
    ifm.sel_2 = b.sel; ifm.wdata_2 = b.wdata;
  endtask

  task automatic model_reset();
    m_pend = 0; m_rv1 = 0; m_rv2 = 0; m_rd1 = '0; m_rd2 = '0; m_cnt = 0;
  endtask

  // One cycle: drive, compare every output against the model, then advance the model.
  task automatic step(input logic fl, input slot_t s1, input slot_t s2);
    slot_t       e1, e2;
    bit          e_ce1, e_ce2, e_stall, same, nrv1, nrv2;
    logic [31:0] nrd1, nrd2;
    int          sat;
    @(negedge clk);
    drive(fl, s1, s2);
    #1;
    e1 = s1; e2 = s2; e_ce1 = 0; e_ce2 = 0; e_stall = 0;
    same = s1.req && s2.req && (s1.addr[31:2] == s2.addr[31:2]);
    if (fl) begin
    end else if (m_pend) begin
      e_ce2 = 1; e2 = m_ps; e2.we = 0;
    end else if (same && s1.we && s2.we) begin
      e_ce2 = 1; e2.sel = s1.sel | s2.sel;
      e2.wdata = (s2.wdata & lane_mask(s2.sel)) | (s1.wdata & ~lane_mask(s2.sel));
    end else if (same && s1.we) begin
      e_ce1 = 1; e_stall = 1;
    end else begin
      e_ce1 = s1.req; e_ce2 = s2.req;
    end
    chk_port("port1", ifm.ram_ce_1, ifm.ram_we_1, ifm.ram_pc_1, ifm.ram_addr_1, ifm.ram_sel_1,
             ifm.ram_wdata_1, e_ce1, e1);
    chk_port("port2", ifm.ram_ce_2, ifm.ram_we_2, ifm.ram_pc_2, ifm.ram_addr_2, ifm.ram_sel_2,
             ifm.ram_wdata_2, e_ce2, e2);
    chk("stall_o", ifm.stall_o, e_stall);
    chk("stall_cnt", ifm.stall_cnt, m_cnt);
    sat = (m_cnt > 3) ? 3 : m_cnt;
    chk("stall_cnt_sat", ifs.stall_cnt, sat);
    chk("rvalid_1", ifm.rvalid_1, m_rv1);
    chk("rdata_1", ifm.rdata_1, m_rv1 ? m_rd1 : 32'h0);
    chk("rvalid_2", ifm.rvalid_2, m_rv2);
    chk("rdata_2", ifm.rdata_2, m_rv2 ? m_rd2 : 32'h0);
    nrv1 = 0; nrv2 = 0; nrd1 = '0; nrd2 = '0;
    if (fl) begin
      m_pend = 0;
    end else if (m_pend) begin
      nrv2 = 1; nrd2 = mmem[m_ps.addr[11:2]]; m_pend = 0;
    end else begin
      if (s1.req) begin
        if (s1.we) mwrite(s1);
        else begin nrv1 = 1; nrd1 = mmem[s1.addr[11:2]]; end
      end
      if (same && s1.we && !s2.we) begin
        m_pend = 1; m_ps = s2;
      end else if (s2.req) begin
        if (s2.we) mwrite(s2);
        else begin nrv2 = 1; nrd2 = mmem[s2.addr[11:2]]; end
      end
    end
    m_cnt += int'(e_stall);
    m_rv1 = nrv1; m_rv2 = nrv2; m_rd1 = nrd1; m_rd2 = nrd2;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ce1"}, ifm.ram_ce_1, 1'b0);
    chk({nm, "_ce2"}, ifm.ram_ce_2, 1'b0);
    chk({nm, "_we1"}, ifm.ram_we_1, 1'b0);
    chk({nm, "_we2"}, ifm.ram_we_2, 1'b0);
    chk({nm, "_stall"}, ifm.stall_o, 1'b0);
    chk({nm, "_rv1"}, ifm.rvalid_1, 1'b0);
    chk({nm, "_rv2"}, ifm.rvalid_2, 1'b0);
    chk({nm, "_rd1"}, ifm.rdata_1, 32'h0);
    chk({nm, "_rd2"}, ifm.rdata_2, 32'h0);
    chk({nm, "_cnt"}, ifm.stall_cnt, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    slot_t idle, a, b;
    idle = mk(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 1024; i++) begin ram[i] = '0; mmem[i] = '0; end
    ram_rd1 = '0; ram_rd2 = '0;
    model_reset();
    rst_n = 1'b0;
    drive(0, mk(1, 1, 32'h4, 32'h40, 4'hF, 32'h1), mk(1, 1, 32'h8, 32'h40, 4'hF, 32'h2));
    #2;
    chk_all_zero("reset");
    drive(0, idle, idle);
    #10 rst_n = 1'b1;

    // RAW serialise
    step(0, mk(1, 1, 32'h10, 32'h80, 4'hF, 32'h12345678), mk(1, 0, 32'h14, 32'h80, 4'hF, 0));
    chk("raw_c0_stall", ifm.stall_o, 1'b1);
    chk("raw_c0_ce1", ifm.ram_ce_1, 1'b1);
    chk("raw_c0_ce2", ifm.ram_ce_2, 1'b0);
    step(0, idle, idle);
    chk("raw_c1_ce2", ifm.ram_ce_2, 1'b1);
    chk("raw_c1_addr2", ifm.ram_addr_2, 32'h80);
    step(0, idle, idle);
    chk("raw_c2_rdata2", ifm.rdata_2, 32'h12345678);
    chk("raw_c2_cnt", ifm.stall_cnt, 32'd1);

    // Pass-through
    step(0, mk(1, 1, 32'h20, 32'h100, 4'hF, 32'h11223344), mk(1, 0, 32'h24, 32'h200, 4'hF, 0));
    chk("pass_ce1", ifm.ram_ce_1, 1'b1);
    chk("pass_ce2", ifm.ram_ce_2, 1'b1);
    chk("pass_stall", ifm.stall_o, 1'b0);
    step(0, idle, idle);
    chk("pass_rvalid2", ifm.rvalid_2, 1'b1);

    // Write merge
    step(0, mk(1, 1, 32'h30, 32'h40, 4'b0011, 32'hAAAABBBB), mk(1, 1, 32'h34, 32'h42, 4'b0110, 32'hCCDDEEFF));
    chk("merge_ce1", ifm.ram_ce_1, 1'b0);
    chk("merge_sel2", ifm.ram_sel_2, 4'b0111);
    chk("merge_wdata2", ifm.ram_wdata_2[23:0], 24'hDDEEBB);
    step(0, mk(1, 0, 32'h38, 32'h40, 4'hF, 0), idle);
    step(0, idle, idle);
    chk("merge_readback", ifm.rdata_1, 32'h00DDEEBB);

    // WAR
    step(0, mk(1, 1, 32'h40, 32'h80, 4'hF, 32'h5), idle);
    step(0, mk(1, 0, 32'h44, 32'h80, 4'hF, 0), mk(1, 1, 32'h48, 32'h80, 4'hF, 32'h9));
    chk("war_stall", ifm.stall_o, 1'b0);
    step(0, mk(1, 0, 32'h4C, 32'h80, 4'hF, 0), idle);
    chk("war_old", ifm.rdata_1, 32'h5);
    step(0, idle, idle);
    chk("war_new", ifm.rdata_1, 32'h9);

    // Flush in SERIAL
    step(0, mk(1, 1, 32'h50, 32'hC0, 4'hF, 32'h77), mk(1, 0, 32'h54, 32'hC0, 4'hF, 0));
    step(1, mk(1, 0, 32'h58, 32'h10, 4'hF, 0), mk(1, 0, 32'h5C, 32'h14, 4'hF, 0));
    chk("flush_ce2", ifm.ram_ce_2, 1'b0);
    chk("flush_stall", ifm.stall_o, 1'b0);
    step(0, idle, idle);
    chk("flush_rvalid2", ifm.rvalid_2, 1'b0);
    chk("flush_cnt", ifm.stall_cnt, 32'd2);

    // Async reset while SERIAL
    step(0, mk(1, 1, 32'h60, 32'hD0, 4'hF, 32'h99), mk(1, 0, 32'h64, 32'hD0, 4'hF, 0));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    chk("async_rst_cnt_s", ifs.stall_cnt, 2'd0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(0, idle, idle);
    chk("post_rst_ce2", ifm.ram_ce_2, 1'b0);

    // Saturation: five RAW events
    for (int k = 0; k < 5; k++) begin
      step(0, mk(1, 1, 32'h70, 32'hE0, 4'hF, k), mk(1, 0, 32'h74, 32'hE0, 4'hF, 0));
      step(0, idle, idle);
    end
    chk("sat_cnt32", ifm.stall_cnt, 32'd5);
    chk("sat_cnt2", ifs.stall_cnt, 2'd3);

    // Randomised traffic over a few words to provoke hazards
    for (int n = 0; n < 2000; n++) begin
      a = mk(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom,
             {25'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00} >> 2 << 2 | 32'($urandom_range(0, 3)),
             4'($urandom), $urandom);
      b = mk(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom,
             32'($urandom_range(0, 31)), 4'($urandom), $urandom);
      step(($urandom_range(0, 15) == 0), a, b);
    end
    step(0, idle, idle);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
